// File: rtl/mem_access_unit.sv
// Data-memory access stage: runs one load/store per request on a req/ack bus
// with timeout, right-aligns read data and passes ALU fields through.
module mem_access_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [5:0]  in_alucode,
   input  logic [31:0] in_alu_result,
   input  logic [31:0] in_store_data,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        out_valid,
   output logic [5:0]  out_alucode,
   output logic [31:0] out_alu_result,
   output logic [31:0] out_load_data,
   output logic        out_misaligned,
   output logic        out_bus_error,
   output logic        busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   localparam logic [5:0] ALU_LB  = 6'd9;
   localparam logic [5:0] ALU_LH  = 6'd10;
   localparam logic [5:0] ALU_LW  = 6'd11;
   localparam logic [5:0] ALU_LBU = 6'd12;
   localparam logic [5:0] ALU_LHU = 6'd13;
   localparam logic [5:0] ALU_SB  = 6'd14;
   localparam logic [5:0] ALU_SH  = 6'd15;
   localparam logic [5:0] ALU_SW  = 6'd16;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [1:0]  state;
   logic [7:0]  cnt;
   logic        is_load_q;
   logic        dec_load;
   logic        dec_store;
   logic        dec_mis;
   logic [3:0]  dec_be;
   logic [31:0] dec_wdata;
   logic [1:0]  off;

   assign off = in_alu_result[1:0];

   always_comb begin
      dec_load  = 1'b0;
      dec_store = 1'b0;
      dec_mis   = 1'b0;
      dec_be    = 4'b1111;
      dec_wdata = '0;
      case (in_alucode)
         ALU_LB, ALU_LBU: dec_load = 1'b1;
         ALU_LH, ALU_LHU: begin
            dec_load = 1'b1;
            dec_mis  = off[0];
         end
         ALU_LW: begin
            dec_load = 1'b1;
            dec_mis  = |off;
         end
         ALU_SB: begin
            dec_store = 1'b1;
            dec_be    = 4'b0001 << off;
            dec_wdata = in_store_data << {off, 3'b000};
         end
         ALU_SH: begin
            dec_store = 1'b1;
            dec_mis   = off[0];
            dec_be    = 4'b0011 << off;
            dec_wdata = in_store_data << {off, 3'b000};
         end
         ALU_SW: begin
            dec_store = 1'b1;
            dec_mis   = |off;
            dec_wdata = in_store_data;
         end
         default: ;
      endcase
   end

   assign in_ready  = (state == IDLE);
   assign busy      = (state != IDLE);
   assign out_valid = (state == RESP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         cnt            <= '0;
         is_load_q      <= 1'b0;
         mem_req        <= 1'b0;
         mem_addr       <= '0;
         mem_we         <= 1'b0;
         mem_be         <= '0;
         mem_wdata      <= '0;
         out_alucode    <= '0;
         out_alu_result <= '0;
         out_load_data  <= '0;
         out_misaligned <= 1'b0;
         out_bus_error  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  out_alucode    <= in_alucode;
                  out_alu_result <= in_alu_result;
                  out_load_data  <= '0;
                  out_misaligned <= dec_mis;
                  out_bus_error  <= 1'b0;
                  is_load_q      <= dec_load;
                  cnt            <= '0;
                  if ((dec_load || dec_store) && !dec_mis) begin
                     state     <= REQ;
                     mem_req   <= 1'b1;
                     mem_addr  <= {in_alu_result[31:2], 2'b00};
                     mem_we    <= dec_store;
                     mem_be    <= dec_be;
                     mem_wdata <= dec_wdata;
                  end else begin
                     state <= RESP;
                  end
               end
            end
            REQ: begin
               // Ack is checked first so an ack in the final timeout cycle still completes.
               if (mem_ack) begin
                  if (is_load_q)
                     out_load_data <= mem_rdata >> {out_alu_result[1:0], 3'b000};
                  mem_req <= 1'b0;
                  state   <= RESP;
               end else if (cnt == CNT_LAST) begin
                  out_bus_error <= 1'b1;
                  mem_req       <= 1'b0;
                  state         <= RESP;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (built with a 4-cycle timeout).
module tb_mem_access_unit;

   localparam logic [5:0] ALU_LH  = 6'd10;
   localparam logic [5:0] ALU_LW  = 6'd11;
   localparam logic [5:0] ALU_LBU = 6'd12;
   localparam logic [5:0] ALU_SB  = 6'd14;
   localparam logic [5:0] ALU_SH  = 6'd15;
   localparam logic [5:0] ALU_SW  = 6'd16;
   localparam logic [5:0] ALU_ADD = 6'd17;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [5:0]  in_alucode = '0;
   logic [31:0] in_alu_result = '0;
   logic [31:0] in_store_data = '0;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        out_valid;
   logic [5:0]  out_alucode;
   logic [31:0] out_alu_result;
   logic [31:0] out_load_data;
   logic        out_misaligned;
   logic        out_bus_error;
   logic        busy;

   int checks = 0;
   int errors = 0;

   mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_alucode(in_alucode),
      .in_alu_result(in_alu_result), .in_store_data(in_store_data),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .out_valid(out_valid), .out_alucode(out_alucode), .out_alu_result(out_alu_result),
      .out_load_data(out_load_data), .out_misaligned(out_misaligned),
      .out_bus_error(out_bus_error), .busy(busy)
   );

   always #5 clk = ~clk;

   // Presents one request for a single accept edge; returns 1 time unit after that edge.
   task automatic issue(input logic [5:0] code, input logic [31:0] addr, input logic [31:0] sdata);
      in_alucode    = code;
      in_alu_result = addr;
      in_store_data = sdata;
      in_valid      = 1'b1;
      @(posedge clk); #1;
      in_valid      = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b exp 1", in_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b exp 0", busy); end
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b exp 0", mem_req); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b exp 0", out_valid); end
      checks++; if ({out_alucode, out_alu_result, out_load_data, out_misaligned, out_bus_error} !== '0) begin
         errors++; $display("FAIL rst_out_fields: got %h/%h/%h/%b/%b exp all 0",
                            out_alucode, out_alu_result, out_load_data, out_misaligned, out_bus_error); end
      checks++; if ({mem_addr, mem_we, mem_be, mem_wdata} !== '0) begin
         errors++; $display("FAIL rst_mem_fields: got %h/%b/%b/%h exp all 0", mem_addr, mem_we, mem_be, mem_wdata); end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_lbu;
      issue(ALU_LBU, 32'h0000_1003, 32'h0);
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL lbu_req: got %b exp 1", mem_req); end
      checks++; if (mem_addr !== 32'h0000_1000) begin errors++; $display("FAIL lbu_addr: got %h exp 00001000", mem_addr); end
      checks++; if (mem_be !== 4'b1111) begin errors++; $display("FAIL lbu_be: got %b exp 1111", mem_be); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL lbu_we: got %b exp 0", mem_we); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lbu_early_valid: got %b exp 0", out_valid); end
      mem_ack = 1'b1; mem_rdata = 32'hAABB_CCDD;
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_rdata = 32'h0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lbu_valid: got %b exp 1", out_valid); end
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL lbu_req_drop: got %b exp 0", mem_req); end
      checks++; if (out_load_data !== 32'h0000_00AA) begin errors++; $display("FAIL lbu_data: got %h exp 000000aa", out_load_data); end
      checks++; if (out_alucode !== ALU_LBU || out_alu_result !== 32'h0000_1003) begin
         errors++; $display("FAIL lbu_pass: got %h/%h exp %h/00001003", out_alucode, out_alu_result, ALU_LBU); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL lbu_after: got valid=%b ready=%b exp 0/1", out_valid, in_ready); end
      checks++; if (out_load_data !== 32'h0000_00AA) begin errors++; $display("FAIL lbu_hold: got %h exp 000000aa", out_load_data); end
   endtask

   // Ack on the 4th REQ cycle coincides with the timeout cycle; the ack must win.
   task automatic test_sh_wait;
      issue(ALU_SH, 32'h0000_2002, 32'h0000_1234);
      for (int i = 0; i < 4; i++) begin
         checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin
            errors++; $display("FAIL sh_req_%0d: got req=%b we=%b exp 1/1", i, mem_req, mem_we); end
         checks++; if (mem_be !== 4'b1100 || mem_wdata !== 32'h1234_0000 || mem_addr !== 32'h0000_2000) begin
            errors++; $display("FAIL sh_bus_%0d: got be=%b wdata=%h addr=%h exp 1100/12340000/00002000", i, mem_be, mem_wdata, mem_addr); end
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sh_early_valid_%0d: got %b exp 0", i, out_valid); end
         if (i == 3) begin mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF; end
         @(posedge clk); #1;
      end
      mem_ack = 1'b0; mem_rdata = 32'h0;
      checks++; if (out_valid !== 1'b1 || mem_req !== 1'b0) begin
         errors++; $display("FAIL sh_valid: got valid=%b req=%b exp 1/0", out_valid, mem_req); end
      checks++; if (out_load_data !== 32'h0 || out_bus_error !== 1'b0) begin
         errors++; $display("FAIL sh_result: got data=%h berr=%b exp 0/0", out_load_data, out_bus_error); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sh_single_pulse: got %b exp 0", out_valid); end
   endtask

   task automatic test_sb;
      issue(ALU_SB, 32'h0000_7001, 32'h1122_33EE);
      checks++; if (mem_be !== 4'b0010 || mem_wdata !== 32'h2233_EE00 || mem_we !== 1'b1) begin
         errors++; $display("FAIL sb_bus: got be=%b wdata=%h we=%b exp 0010/2233ee00/1", mem_be, mem_wdata, mem_we); end
      mem_ack = 1'b1;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sb_valid: got %b exp 1", out_valid); end
      @(posedge clk); #1;
   endtask

   task automatic test_misaligned;
      issue(ALU_LW, 32'h0000_3001, 32'h0);
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL mis_req: got %b exp 0", mem_req); end
      checks++; if (out_valid !== 1'b1 || out_misaligned !== 1'b1) begin
         errors++; $display("FAIL mis_valid: got valid=%b mis=%b exp 1/1", out_valid, out_misaligned); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mis_ready_resp: got %b exp 0", in_ready); end
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++; $display("FAIL mis_after: got ready=%b valid=%b exp 1/0", in_ready, out_valid); end
      checks++; if (out_misaligned !== 1'b1) begin errors++; $display("FAIL mis_hold: got %b exp 1", out_misaligned); end
   endtask

   task automatic test_nonmem;
      issue(ALU_ADD, 32'h1234_5678, 32'h0);
      checks++; if (mem_req !== 1'b0 || out_valid !== 1'b1) begin
         errors++; $display("FAIL nm_valid: got req=%b valid=%b exp 0/1", mem_req, out_valid); end
      checks++; if (out_alu_result !== 32'h1234_5678 || out_load_data !== 32'h0 || out_misaligned !== 1'b0) begin
         errors++; $display("FAIL nm_fields: got res=%h data=%h mis=%b exp 12345678/0/0", out_alu_result, out_load_data, out_misaligned); end
      @(posedge clk); #1;
   endtask

   task automatic test_timeout;
      issue(ALU_LW, 32'h0000_4000, 32'h0);
      for (int i = 0; i < 4; i++) begin
         checks++; if (mem_req !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL to_req_%0d: got req=%b valid=%b exp 1/0", i, mem_req, out_valid); end
         @(posedge clk); #1;
      end
      checks++; if (mem_req !== 1'b0 || out_valid !== 1'b1) begin
         errors++; $display("FAIL to_end: got req=%b valid=%b exp 0/1", mem_req, out_valid); end
      checks++; if (out_bus_error !== 1'b1 || out_load_data !== 32'h0) begin
         errors++; $display("FAIL to_flags: got berr=%b data=%h exp 1/0", out_bus_error, out_load_data); end
      @(posedge clk); #1;
      mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0 || out_load_data !== 32'h0) begin
            errors++; $display("FAIL to_idle_ack_%0d: got valid=%b busy=%b req=%b data=%h exp 0/0/0/0",
                               i, out_valid, busy, mem_req, out_load_data); end
      end
      mem_ack = 1'b0; mem_rdata = 32'h0;
   endtask

   task automatic test_reset_mid;
      issue(ALU_SW, 32'h0000_5000, 32'hCAFE_F00D);
      checks++; if (mem_req !== 1'b1 || mem_wdata !== 32'hCAFE_F00D || mem_be !== 4'b1111 || mem_we !== 1'b1) begin
         errors++; $display("FAIL rm_bus: got req=%b wdata=%h be=%b we=%b exp 1/cafef00d/1111/1", mem_req, mem_wdata, mem_be, mem_we); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rm_async_drop: got %b exp 0", mem_req); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++; if (out_valid !== 1'b0 || mem_req !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL rm_quiet_%0d: got valid=%b req=%b ready=%b exp 0/0/1", i, out_valid, mem_req, in_ready); end
      end
      issue(ALU_LH, 32'h0000_6002, 32'h0);
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_6000) begin
         errors++; $display("FAIL rm_next_req: got req=%b addr=%h exp 1/00006000", mem_req, mem_addr); end
      mem_ack = 1'b1; mem_rdata = 32'h89AB_0000;
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_rdata = 32'h0;
      checks++; if (out_valid !== 1'b1 || out_load_data !== 32'h0000_89AB) begin
         errors++; $display("FAIL rm_next_data: got valid=%b data=%h exp 1/000089ab", out_valid, out_load_data); end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_lbu();
      test_sh_wait();
      test_sb();
      test_misaligned();
      test_nonmem();
      test_timeout();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Data-memory access stage of the CPU. Sits between the EX-stage ALU output and the load-result formatting stage.
- Accepts one load/store request at a time and runs a req/ack transaction on the data bus. Tolerates variable bus latency and has a timeout.
- Right-aligns read data to lane 0 so the formatting stage can sign- or zero-extend from bits [7:0] or [15:0].
- Passes alucode and ALU result through alongside the loaded data.

Parameters:
- TIMEOUT_CYCLES, 255: maximum REQ-state cycles waiting for mem_ack before a bus error is reported (range 1..255).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  EX stage presents a request
- in_ready  output  1  unit can accept a request; high only in IDLE
- in_alucode  input  6  operation code from define.vh (ALU_LB/LBU/LH/LHU/LW/SB/SH/SW or non-memory)
- in_alu_result  input  32  ALU result; the effective address for memory ops
- in_store_data  input  32  rs2 value for stores
- mem_req  output  1  bus request, held until ack
- mem_addr  output  32  word-aligned address {addr[31:2],2'b00}
- mem_we  output  1  1 = write
- mem_be  output  4  byte enables
- mem_wdata  output  32  lane-shifted write data
- mem_ack  input  1  bus completes the transfer this cycle
- mem_rdata  input  32  read word, valid with mem_ack
- out_valid  output  1  one-cycle pulse: result fields valid
- out_alucode  output  6  captured alucode
- out_alu_result  output  32  captured ALU result
- out_load_data  output  32  read word shifted right by 8*addr[1:0]; 0 for stores and non-memory ops
- out_misaligned  output  1  access was misaligned (valid with out_valid)
- out_bus_error  output  1  bus timed out (valid with out_valid)
- busy  output  1  state != IDLE; used as the pipeline stall

Behaviour:
- Reset values: state IDLE, all outputs 0; in_ready follows state and is therefore 1.
- States:
  - IDLE: in_ready=1.
  - REQ: mem_req=1.
  - RESP: out_valid=1 for exactly one cycle, then IDLE.
- IDLE, on in_valid=1 at a clock edge, latch alucode, alu_result and store_data into the out_* registers, then:
  - Non-memory alucode -> RESP; out_load_data=0, no bus activity.
  - Misaligned access -> RESP with out_misaligned=1, no bus activity. Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - Otherwise -> REQ; timeout counter cleared.
- Bus drive in REQ; all mem_* outputs are registered and stable for the whole REQ phase:
  - mem_we=1 for SB/SH/SW.
  - mem_be: SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111; loads 4'b1111.
  - mem_wdata: store_data<<(8*addr[1:0]) for SB/SH; store_data for SW; 0 for loads.
- REQ, mem_ack=1: capture the shifted mem_rdata (loads only), drop mem_req at the same edge -> RESP.
  - Ack may arrive in the first REQ cycle, giving minimum latency: accept edge N, mem_req high in cycle N+1, out_valid in cycle N+2.
- REQ, no ack: counter increments.
  - When counter reaches TIMEOUT_CYCLES-1 without ack -> RESP with out_bus_error=1, out_load_data=0, mem_req dropped.
  - An ack in that same cycle wins over the timeout.
- mem_ack outside REQ is ignored.
- out_* data fields hold their values after the RESP pulse until the next accept.
- in_valid while busy is ignored; the upstream stage holds its request until in_ready is high.
- Reset asserted mid-transaction clears mem_req immediately (asynchronously). The bus slave must tolerate an abandoned request; no out_valid is produced for it.

Test Plan:
- Reset pulse while IDLE -> in_ready=1, busy=0, mem_req=0, all out_* = 0.
- LBU addr 0x1003, mem_rdata 0xAABBCCDD acked in the first REQ cycle -> mem_addr 0x1000, mem_be 4'b1111, out_valid 2 cycles after accept, out_load_data 0x000000AA.
- SH addr 0x2002, store_data 0x00001234, ack after 3 wait cycles -> mem_we=1, mem_be 4'b1100, mem_wdata 0x12340000 stable for 4 cycles, out_valid once, out_load_data 0.
- LW addr 0x3001 -> no mem_req; out_valid 1 cycle after accept with out_misaligned=1; in_ready back to 1 the following cycle.
- LW with TIMEOUT_CYCLES=4, ack never given -> mem_req high exactly 4 cycles, then out_bus_error=1 pulse; a later ack while IDLE is ignored.
- Reset asserted during REQ of an SW -> mem_req falls without waiting for a clock edge; no out_valid afterwards; next request is processed normally.
